watch_dp: RTL
=============

WATCH_DP -- requirements
Module: watch_dp

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, meaning time-base rate; one tick = 10 ms.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port i_run, input, 1 bit, time-base enable from the watch control unit.
REQ-006 SHALL have port i_clear, input, 1 bit, synchronous clear request.
REQ-007 SHALL have port i_add, input, 3 bits, adjust request: [0] sec, [1] min, [2] hour.
REQ-008 SHALL have port o_msec, output, 7 bits, centiseconds 0..99.
REQ-009 SHALL have port o_sec, output, 6 bits, seconds 0..59.
REQ-010 SHALL have port o_min, output, 6 bits, minutes 0..59.
REQ-011 SHALL have port o_hour, output, 5 bits, hours 0..23.

Function
REQ-012 SHALL generate a one-cycle tick when the divider counter reaches CLK_FREQ/TICK_HZ-1; the counter then wraps to 0.
REQ-013 SHALL advance the divider only while i_run=1; with i_run=0 it holds, so pause/resume keeps the partial period.
REQ-014 SHALL, on tick, increment o_msec; at 99 it wraps to 0 and carries into o_sec.
REQ-015 SHALL chain carries: sec 59->0 carries into min, min 59->0 into hour, hour 23->0 with no further carry.
REQ-016 SHALL update outputs one cycle after the tick cycle; the full carry chain resolves in that same cycle (23:59:59.99 -> 00:00:00.00 in one step).
REQ-017 SHALL, for each asserted add event, increment the selected field by 1 modulo its range, with no carry to higher fields.
REQ-018 SHALL process simultaneous add bits independently, each field incrementing.
REQ-019 SHALL give add priority for a field when an add event and a tick carry-in coincide for it: the carry-in is discarded; lower fields still update normally.
REQ-020 SHALL, on i_clear=1, zero all four fields and the divider in the next cycle; clear overrides tick and add in the same cycle.
REQ-021 SHALL apply add events regardless of i_run.

Reset
REQ-022 SHALL, on reset assertion, immediately and asynchronously set o_msec=0, o_sec=0, o_min=0, o_hour=12, divider=0, and the edge-detect history (when present) to 0.
REQ-023 SHALL resume normal counting on the first rising clk after reset deasserts; reset asserted mid-carry discards the carry.

Configuration
REQ-024 SHALL support macro WATCH_DP_ADD_EDGE_EN.
- Defined: an add event is a 0->1 transition of an i_add bit, detected against a registered copy; a held bit yields exactly one increment.
- Undefined: an add event is each clock cycle in which the i_add bit is 1; the level is used directly with no history registers.

Structure
REQ-025 SHALL take field maxima (99, 59, 59, 23), the reset hour (12) and the field widths from shared package watch_pkg.
REQ-026 SHALL implement the divider as sub-module tick_gen, with ports clk, reset, i_en, i_clear and o_tick, parameterized by CLK_FREQ and TICK_HZ.

Verification
All scenarios use CLK_FREQ=1000 and TICK_HZ=100, giving a divide of 10.
REQ-027 SHALL check: reset pulse -> outputs 12:00:00.00 immediately, before any clock edge.
REQ-028 SHALL check: i_run=1 for 1000 cycles after reset -> o_sec=1, o_msec=0; i_run=0 for 50 cycles -> values frozen.
REQ-029 SHALL check: preload via adds to 23:59:59, run until msec=99, then one tick -> 00:00:00.00 in one cycle.
REQ-030 SHALL check: i_add=3'b111 held 3 cycles -> edge build gives sec, min and hour each +1; level build gives each +3, with 59->0 wrap and no carry.
REQ-031 SHALL check: i_add[0] pulse coincident with a msec 99->0 tick -> o_sec +1 only (carry discarded), o_msec=0.
REQ-032 SHALL check: i_clear with i_run=1 and i_add=3'b001 in the same cycle -> all fields 0 next cycle; the divider restarts and the first tick comes 10 cycles later.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared field widths, limits and time record for the watch datapath.
package watch_pkg;

    localparam int MSEC_W  = 7;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;
    localparam int FIELD_W = 7;

    localparam logic [MSEC_W-1:0] MSEC_MAX   = MSEC_W'(99);
    localparam logic [SEC_W-1:0]  SEC_MAX    = SEC_W'(59);
    localparam logic [MIN_W-1:0]  MIN_MAX    = MIN_W'(59);
    localparam logic [HOUR_W-1:0] HOUR_MAX   = HOUR_W'(23);
    localparam logic [HOUR_W-1:0] RESET_HOUR = HOUR_W'(12);

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } watch_time_t;

    // Fields are widened to FIELD_W so one helper serves every field.
    function automatic logic [FIELD_W-1:0] wrapInc(input logic [FIELD_W-1:0] value,
                                                   input logic [FIELD_W-1:0] maxVal);
        return (value == maxVal) ? '0 : value + FIELD_W'(1);
    endfunction

endpackage

// File: rtl/watch_dp_if.sv
// Control and time-display bundle between the watch control unit and watch_dp.
interface watch_dp_if;
    import watch_pkg::*;

    logic              run;
    logic              clear;
    logic [2:0]        add;
    logic [MSEC_W-1:0] msec;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;

    modport master (output run, clear, add, input msec, sec, min, hour);
    modport slave  (input run, clear, add, output msec, sec, min, hour);
endinterface

// File: rtl/tick_gen.sv
// Time-base divider: one-cycle tick every CLK_FREQ/TICK_HZ enabled cycles.
module tick_gen #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);
    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Tick is combinational so the field update lands on the edge that wraps the counter.
    assign o_tick = i_en && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/watch_dp.sv
// Stopwatch/clock datapath: hh:mm:ss.cc counter with add and clear controls.
// Build option WATCH_DP_ADD_EDGE_EN turns add requests into rising-edge events.
module watch_dp
    import watch_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic              i_clear,
    input  logic [2:0]        i_add,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour
);
    logic        w_tick;
    logic [2:0]  w_addEvt;
    logic        w_msecWrap;
    logic        w_secCarry;
    logic        w_minCarry;
    watch_time_t r_time;
    watch_time_t w_next;

    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tickGen (
        .clk     (clk),
        .reset   (reset),
        .i_en    (i_run),
        .i_clear (i_clear),
        .o_tick  (w_tick)
    );

`ifdef WATCH_DP_ADD_EDGE_EN
    logic [2:0] r_addPrev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addPrev <= '0;
        end else begin
            r_addPrev <= i_add;
        end
    end

    assign w_addEvt = i_add & ~r_addPrev;
`else
    assign w_addEvt = i_add;
`endif

    // An add on a field swallows that field's carry-in, so no carry leaves it either.
    always_comb begin
        w_next     = r_time;
        w_msecWrap = 1'b0;
        w_secCarry = 1'b0;
        w_minCarry = 1'b0;

        if (w_tick) begin
            w_msecWrap  = (r_time.msec == MSEC_MAX);
            w_next.msec = MSEC_W'(wrapInc(FIELD_W'(r_time.msec), FIELD_W'(MSEC_MAX)));
        end

        if (w_addEvt[0] || w_msecWrap) begin
            w_next.sec = SEC_W'(wrapInc(FIELD_W'(r_time.sec), FIELD_W'(SEC_MAX)));
            w_secCarry = !w_addEvt[0] && (r_time.sec == SEC_MAX);
        end

        if (w_addEvt[1] || w_secCarry) begin
            w_next.min = MIN_W'(wrapInc(FIELD_W'(r_time.min), FIELD_W'(MIN_MAX)));
            w_minCarry = !w_addEvt[1] && (r_time.min == MIN_MAX);
        end

        if (w_addEvt[2] || w_minCarry) begin
            w_next.hour = HOUR_W'(wrapInc(FIELD_W'(r_time.hour), FIELD_W'(HOUR_MAX)));
        end

        if (i_clear) begin
            w_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_time.hour <= RESET_HOUR;
            r_time.min  <= '0;
            r_time.sec  <= '0;
            r_time.msec <= '0;
        end else begin
            r_time <= w_next;
        end
    end

    assign o_msec = r_time.msec;
    assign o_sec  = r_time.sec;
    assign o_min  = r_time.min;
    assign o_hour = r_time.hour;
endmodule
